// File: rtl/modulator_pkg.sv
// rtl/modulator_pkg.sv - shared constants, types and helpers for the DSSS modulator
package modulator_pkg;

  localparam int SIZE_INPUT_BIT  = 8;
  localparam int SIZE_OUTPUT_BIT = 32;
  localparam int SIZE_BIT_PACK   = 1976;
  localparam int SISE_PREAMBLE   = 32;
  localparam logic [31:0] PREAMBLE = 32'h1ACFFC1D;
  localparam logic signed [15:0] AMP = 16'sd8191;

  // Packet RAM geometry: 247 bytes, first 4 are the preamble
  localparam int PACK_BYTES       = SIZE_BIT_PACK / SIZE_INPUT_BIT;
  localparam int PRE_BYTES        = SISE_PREAMBLE / SIZE_INPUT_BIT;
  localparam int ADDR_FIRST_WRITE = PRE_BYTES;
  localparam int PAYLOAD_BYTES    = PACK_BYTES - PRE_BYTES;

  localparam int BIT_W  = $clog2(SIZE_BIT_PACK);
  localparam int ADDR_W = $clog2(PACK_BYTES);
  localparam int CNT_W  = $clog2(PAYLOAD_BYTES + 1);

  // PN generator: x^7 + x^6 + 1, feedback from stages 7 and 6
  localparam int LFSR_W = 7;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h7F;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'b1100000;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } iq_t;

  // Preamble byte idx (0 = most significant, sent first)
  function automatic logic [7:0] preamble_byte(input logic [1:0] idx);
    logic [31:0] v;
    v = PREAMBLE << {idx, 3'b000};
    return v[31:24];
  endfunction

  // Chip to constellation point: 0 -> +AMP, 1 -> -AMP on both rails
  function automatic iq_t map_chip(input logic c);
    iq_t s;
    s.i = c ? -AMP : AMP;
    s.q = s.i;
    return s;
  endfunction

endpackage

// File: rtl/modulator_core_pn_gen.sv
// rtl/modulator_core_pn_gen.sv - Fibonacci LFSR chip source with reload and step
module pn_gen
  import modulator_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_step,
  output logic o_chip
);

  logic [LFSR_W-1:0] r_state;
  logic              w_fb;

  assign w_fb   = ^(r_state & LFSR_TAPS);
  assign o_chip = r_state[0];

  // Reload to the seed at each packet bit, otherwise advance once per chip
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)     r_state <= LFSR_SEED;
    else if (i_load) r_state <= LFSR_SEED;
    else if (i_step) r_state <= {r_state[LFSR_W-2:0], w_fb};
  end

endmodule

// File: rtl/modulator_core.sv
// rtl/modulator_core.sv - packet DSSS modulator with ping-pong payload buffers
module modulator_core
  import modulator_pkg::*;
#(
  parameter int CHIPS_PER_BIT = 120,
  parameter int SPS           = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [SIZE_INPUT_BIT-1:0]  i_data,
  input  logic                       i_valid_input,
  output logic                       o_ready,
  output logic [SIZE_OUTPUT_BIT-1:0] o_data,
  output logic                       o_valid_output
);

  localparam int CHIP_W = (CHIPS_PER_BIT > 1) ? $clog2(CHIPS_PER_BIT) : 1;
  localparam int SMP_W  = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(CHIPS_PER_BIT - 1);
  localparam logic [SMP_W-1:0]  SMP_LAST  = SMP_W'(SPS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SIZE_BIT_PACK - 1);

  logic [7:0]        r_ram0 [PACK_BYTES];
  logic [7:0]        r_ram1 [PACK_BYTES];

  logic [BIT_W-1:0]  r_bit;
  logic [CHIP_W-1:0] r_chip;
  logic [SMP_W-1:0]  r_smp;

  logic              r_tx_sel;
  logic              r_blank;
  logic [CNT_W-1:0]  r_fill_cnt;
  logic              r_fill_full;

  logic [7:0]        r_byte;
  logic [2:0]        r_sel;
  logic              r_pay;
  logic              r_v1;

  logic              w_smp_last, w_chip_last, w_bit_last, w_pkt_start;
  logic              w_swap, w_accept, w_wr_sel, w_pn, w_bit, w_chip;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
  logic [7:0]        w_rd_byte;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_full_next;
  iq_t               w_iq;

  assign w_smp_last  = (r_smp == SMP_LAST);
  assign w_chip_last = (r_chip == CHIP_LAST);
  assign w_bit_last  = (r_bit == BIT_LAST);
  assign w_pkt_start = (r_bit == '0) && (r_chip == '0) && (r_smp == '0);

  assign w_swap    = w_pkt_start && r_fill_full;
  assign w_accept  = i_valid_input && o_ready;
  // A byte landing on a swap edge belongs to the freshly emptied buffer
  assign w_wr_sel  = w_swap ? r_tx_sel : ~r_tx_sel;
  assign w_wr_addr = ADDR_W'(ADDR_FIRST_WRITE) + (w_swap ? '0 : ADDR_W'(r_fill_cnt));

  // Next fill state; o_ready is registered from it so it drops right after the last byte
  always_comb begin
    w_cnt_next  = r_fill_cnt;
    w_full_next = r_fill_full;
    if (w_swap) begin
      w_cnt_next  = w_accept ? CNT_W'(1) : '0;
      w_full_next = 1'b0;
    end else if (w_accept) begin
      w_cnt_next  = r_fill_cnt + 1'b1;
      w_full_next = (r_fill_cnt == CNT_W'(PAYLOAD_BYTES - 1));
    end
  end

  // Payload RAM writes into the current fill buffer
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      if (w_wr_sel) r_ram1[w_wr_addr] <= i_data;
      else          r_ram0[w_wr_addr] <= i_data;
    end
  end

  // Fill bookkeeping, buffer swap and blank-packet decision at each packet start
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fill_cnt  <= '0;
      r_fill_full <= 1'b0;
      o_ready     <= 1'b0;
      r_tx_sel    <= 1'b0;
      r_blank     <= 1'b1;
    end else begin
      r_fill_cnt  <= w_cnt_next;
      r_fill_full <= w_full_next;
      o_ready     <= ~w_full_next;
      if (w_pkt_start) begin
        r_blank <= ~r_fill_full;
        if (r_fill_full) r_tx_sel <= ~r_tx_sel;
      end
    end
  end

  // Sample / chip / bit position counters, free running after reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_smp  <= '0;
      r_chip <= '0;
      r_bit  <= '0;
    end else begin
      r_smp <= w_smp_last ? '0 : r_smp + 1'b1;
      if (w_smp_last) begin
        r_chip <= w_chip_last ? '0 : r_chip + 1'b1;
        if (w_chip_last) r_bit <= w_bit_last ? '0 : r_bit + 1'b1;
      end
    end
  end

  // Preamble bytes are constant; the rest comes from the transmit buffer
  assign w_rd_addr = r_bit[BIT_W-1:3];
  always_comb begin
    w_rd_byte = r_tx_sel ? r_ram1[w_rd_addr] : r_ram0[w_rd_addr];
    if (w_rd_addr < ADDR_W'(PRE_BYTES)) w_rd_byte = preamble_byte(w_rd_addr[1:0]);
  end

  // First pipeline stage: registered byte read plus bit select
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_byte <= '0;
      r_sel  <= '0;
      r_pay  <= 1'b0;
      r_v1   <= 1'b0;
    end else begin
      r_byte <= w_rd_byte;
      r_sel  <= r_bit[2:0];
      r_pay  <= (w_rd_addr >= ADDR_W'(PRE_BYTES));
      r_v1   <= 1'b1;
    end
  end

  pn_gen u_pn_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  ((r_chip == '0) && (r_smp == '0)),
    .i_step  ((r_chip != '0) && (r_smp == '0)),
    .o_chip  (w_pn)
  );

  assign w_bit  = r_byte[3'd7 - r_sel] & ~(r_blank & r_pay);
  assign w_chip = w_bit ^ w_pn;
  assign w_iq   = map_chip(w_chip);

  // Second stage: spread bit mapped to the output sample
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_data         <= '0;
      o_valid_output <= 1'b0;
    end else begin
      o_data         <= r_v1 ? w_iq : '0;
      o_valid_output <= r_v1;
    end
  end

endmodule

// File: tb/tb_modulator_core.sv
// tb/tb_modulator_core.sv - directed self-checking bench for modulator_core
module tb_modulator_core;

  localparam int CH_T  = 4;
  localparam int SPS_T = 2;
  localparam int SPB   = CH_T * SPS_T;
  localparam int NBITS = 1976;
  localparam int PKT   = NBITS * SPB;
  localparam logic [31:0] PRE   = 32'h1ACFFC1D;
  localparam logic [31:0] S_POS = 32'h1FFF1FFF;
  localparam logic [31:0] S_NEG = 32'hE001E001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i_data = 8'h00;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] o_data;
  logic        o_valid;

  int checks = 0;
  int errors = 0;
  logic [7:0] pay [243];
  logic       pn_model [CH_T];

  always #5 clk = ~clk;

  modulator_core #(.CHIPS_PER_BIT(CH_T), .SPS(SPS_T)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_data         (i_data),
    .i_valid_input  (i_valid),
    .o_ready        (o_ready),
    .o_data         (o_data),
    .o_valid_output (o_valid)
  );

  function automatic logic [31:0] exp_sample(input int k, input bit blank);
    int   n, j;
    logic b;
    logic [7:0] by;
    n = k / SPB;
    j = (k / SPS_T) % CH_T;
    if (n < 32) b = PRE[31 - n];
    else if (blank) b = 1'b0;
    else begin
      by = pay[(n - 32) / 8];
      b  = by[7 - ((n - 32) % 8)];
    end
    return (b ^ pn_model[j]) ? S_NEG : S_POS;
  endfunction

  task automatic build_model();
    logic [6:0] s;
    s = 7'h7F;
    for (int j = 0; j < CH_T; j++) begin
      pn_model[j] = s[0];
      s = {s[5:0], s[6] ^ s[5]};
    end
    for (int k = 0; k < 243; k++) pay[k] = (k < 100) ? 8'hFF : (8'(k) ^ 8'h5A);
  endtask

  task automatic check_packet(input bit blank, input int nsamp, input string name);
    int bad = 0;
    int first_k = 0;
    logic [31:0] got = '0, exp = '0, e;
    logic gv = 1'b0;
    for (int k = 0; k < nsamp; k++) begin
      @(negedge clk);
      e = exp_sample(k, blank);
      if (o_valid !== 1'b1 || o_data !== e) begin
        if (bad == 0) begin
          first_k = k; got = o_data; exp = e; gv = o_valid;
        end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d bad samples, first at %0d got data=%h valid=%b expected data=%h valid=1",
               name, bad, first_k, got, gv, exp);
    end
  endtask

  task automatic send_bytes(input int start, input int n);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 2000) begin
      @(negedge clk);
      if (o_ready === 1'b1) begin
        i_valid = 1'b1;
        i_data  = pay[start + k];
        k++;
      end else begin
        i_valid = 1'b0;
        guard++;
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL send_bytes: sent %0d bytes, required %0d (o_ready stuck low)", k, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 3;
    if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", o_ready); end
    if (o_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", o_data); end
    if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    repeat (8) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_valid_start(input string name);
    @(negedge clk);
    checks += 3;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_1st: got %b expected 0", name, o_valid); end
    if (o_data !== 32'h0) begin errors++; $display("FAIL %s_data_1st: got %h expected 0", name, o_data); end
    if (o_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_1st: got %b expected 1", name, o_ready); end
  endtask

  task automatic test_partial_fill();
    fork
      check_packet(1'b1, PKT, "pkt0_blank");
      send_bytes(0, 100);
    join
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL partial_ready: got %b expected 1", o_ready); end
  endtask

  task automatic test_fill_full();
    fork
      check_packet(1'b1, PKT, "pkt1_blank_with_partial");
      begin
        int drop_bad = 0;
        send_bytes(100, 143);
        checks++;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL ready_after_full: got %b expected 0", o_ready); end
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          i_valid = 1'b1;
          i_data  = 8'h00;
          if (o_ready !== 1'b0) drop_bad++;
        end
        @(negedge clk);
        i_valid = 1'b0;
        checks++;
        if (drop_bad != 0) begin
          errors++;
          $display("FAIL drop_ready: o_ready high %0d of 10 cycles, expected 0", drop_bad);
        end
      end
    join
  endtask

  task automatic test_data_packet();
    check_packet(1'b0, PKT, "pkt2_data");
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL ready_after_swap: got %b expected 1", o_ready); end
  endtask

  task automatic test_async_reset();
    repeat (37) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (o_data !== 32'h0) begin errors++; $display("FAIL async_data: got %h expected 0", o_data); end
    if (o_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", o_valid); end
    if (o_ready !== 1'b0) begin errors++; $display("FAIL async_ready: got %b expected 0", o_ready); end
    repeat (11) @(negedge clk);
    rst = 1'b0;
    test_valid_start("post_reset");
    check_packet(1'b1, 48 * SPB, "post_reset_blank");
  endtask

  initial begin
    build_model();
    test_reset();
    test_valid_start("first");
    test_partial_fill();
    test_fill_full();
    test_data_packet();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
